// File: rtl/riscv_v_csr_ctrl.sv
// rtl/riscv_v_csr_ctrl.sv - vector CSR write-side controller (Zicsr + vsetvl/vsetvli)
// Read and write happen in separate cycles because the CSR file bypasses data_in to data_out.
module riscv_v_csr_ctrl #(
    parameter int XLEN     = 32,
    parameter int VLEN     = 128,
    parameter int MAX_LMUL = 8,
    parameter int VL_W     = $clog2(VLEN / 8 * MAX_LMUL)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [XLEN-1:0] req_vtype,
    input  logic            req_rs1_x0,
    input  logic            req_rd_x0,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    input  logic [8:0]      csr_vtype_rdata,
    output logic [8:0]      csr_vtype_wdata,
    output logic            csr_vtype_wr_en,
    input  logic [VL_W-1:0] csr_vl_rdata,
    output logic [VL_W-1:0] csr_vl_wdata,
    output logic            csr_vl_wr_en,
    input  logic [VL_W-1:0] csr_vstart_rdata,
    output logic [VL_W-1:0] csr_vstart_wdata,
    output logic            csr_vstart_wr_en,
    input  logic [1:0]      csr_vxrm_rdata,
    output logic [1:0]      csr_vxrm_wdata,
    output logic            csr_vxrm_wr_en,
    input  logic            csr_vxsat_rdata,
    output logic            csr_vxsat_wdata,
    output logic            csr_vxsat_wr_en
);

    localparam logic [2:0] OP_RW = 3'd0;
    localparam logic [2:0] OP_RS = 3'd1;
    localparam logic [2:0] OP_RC = 3'd2;
    localparam logic [2:0] OP_VSETVLI = 3'd3;
    localparam logic [2:0] OP_VSETVL  = 3'd4;
    localparam logic [XLEN-1:0] VL_MAX = XLEN'((1 << VL_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   vtype_req_q, vtype_req_d;
    logic              rs1_x0_q, rs1_x0_d;
    logic              rd_x0_q, rd_x0_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              illegal_q, illegal_d;
    logic [4:0]        we_q, we_d;            // {vtype, vl, vstart, vxrm, vxsat}
    logic [8:0]        vtype_wd_q, vtype_wd_d;
    logic [VL_W-1:0]   vl_wd_q, vl_wd_d;
    logic [VL_W-1:0]   vstart_wd_q, vstart_wd_d;
    logic [1:0]        vxrm_wd_q, vxrm_wd_d;
    logic              vxsat_wd_q, vxsat_wd_d;

    logic [XLEN-1:0]   old_val;
    logic              csr_map, csr_ro, do_wr;
    logic [VL_W-1:0]   csr_new;
    logic [2:0]        vsew, vlmul;
    logic [XLEN-1:0]   vlen_sew, vlmax_raw, vlmax, avl;
    logic              vill;
    logic [VL_W-1:0]   vl_new;

    always_comb begin
        old_val = '0;
        csr_map = 1'b1;
        csr_ro  = 1'b0;
        case (addr_q)
            12'h008: old_val = XLEN'(csr_vstart_rdata);
            12'h009: old_val = XLEN'(csr_vxsat_rdata);
            12'h00A: old_val = XLEN'(csr_vxrm_rdata);
            12'h00F: old_val = XLEN'({csr_vxrm_rdata, csr_vxsat_rdata});
            12'hC20: begin old_val = XLEN'(csr_vl_rdata); csr_ro = 1'b1; end
            12'hC21: begin
                old_val = {csr_vtype_rdata[8], {(XLEN-9){1'b0}}, csr_vtype_rdata[7:0]};
                csr_ro  = 1'b1;
            end
            12'hC22: begin old_val = XLEN'(VLEN / 8); csr_ro = 1'b1; end
            default: csr_map = 1'b0;
        endcase
        case (op_q)
            OP_RW:   csr_new = wdata_q[VL_W-1:0];
            OP_RS:   csr_new = old_val[VL_W-1:0] | wdata_q[VL_W-1:0];
            default: csr_new = old_val[VL_W-1:0] & ~wdata_q[VL_W-1:0];
        endcase
        do_wr = (op_q == OP_RW) || !rs1_x0_q;
    end

    // VLMAX = (VLEN/SEW) scaled by LMUL; with ELEN==VLEN, SEW > ELEN*LMUL is exactly VLMAX==0.
    always_comb begin
        vsew      = vtype_req_q[5:3];
        vlmul     = vtype_req_q[2:0];
        vlen_sew  = XLEN'(VLEN / 8) >> vsew;
        vlmax_raw = vlmul[2] ? (vlen_sew >> (4'd8 - {1'b0, vlmul})) : (vlen_sew << vlmul[1:0]);
        vill      = (|vtype_req_q[XLEN-1:8]) || (vlmul == 3'b100) || (vsew > 3'b100) ||
                    (vlmax_raw == '0);
        vlmax     = (vlmax_raw > VL_MAX) ? VL_MAX : vlmax_raw;
        if (!rs1_x0_q)     avl = wdata_q;
        else if (!rd_x0_q) avl = vlmax;
        else               avl = XLEN'(csr_vl_rdata);
        vl_new = (avl < vlmax) ? avl[VL_W-1:0] : vlmax[VL_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        vtype_req_d = vtype_req_q;
        rs1_x0_d    = rs1_x0_q;
        rd_x0_d     = rd_x0_q;
        rdata_d     = rdata_q;
        illegal_d   = illegal_q;
        we_d        = we_q;
        vtype_wd_d  = vtype_wd_q;
        vl_wd_d     = vl_wd_q;
        vstart_wd_d = vstart_wd_q;
        vxrm_wd_d   = vxrm_wd_q;
        vxsat_wd_d  = vxsat_wd_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    addr_d      = req_csr_addr;
                    wdata_d     = req_wdata;
                    vtype_req_d = req_vtype;
                    rs1_x0_d    = req_rs1_x0;
                    rd_x0_d     = req_rd_x0;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                state_d   = S_WRITE;
                we_d      = '0;
                illegal_d = 1'b0;
                rdata_d   = '0;
                if (op_q == OP_VSETVLI || op_q == OP_VSETVL) begin
                    we_d        = 5'b11100;
                    vstart_wd_d = '0;
                    vtype_wd_d  = vill ? 9'h100 : {1'b0, vtype_req_q[7:0]};
                    vl_wd_d     = vill ? '0 : vl_new;
                    rdata_d     = vill ? '0 : XLEN'(vl_new);
                end else if (op_q > OP_RC || !csr_map || (csr_ro && do_wr)) begin
                    illegal_d = 1'b1;
                end else begin
                    rdata_d     = old_val;
                    vstart_wd_d = csr_new;
                    vxsat_wd_d  = csr_new[0];
                    vxrm_wd_d   = (addr_q == 12'h00F) ? csr_new[2:1] : csr_new[1:0];
                    if (do_wr) begin
                        case (addr_q)
                            12'h008: we_d = 5'b00100;
                            12'h009: we_d = 5'b00001;
                            12'h00A: we_d = 5'b00010;
                            12'h00F: we_d = 5'b00011;
                            default: we_d = 5'b00000;
                        endcase
                    end
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            vtype_req_q <= '0;
            rs1_x0_q    <= 1'b0;
            rd_x0_q     <= 1'b0;
            rdata_q     <= '0;
            illegal_q   <= 1'b0;
            we_q        <= '0;
            vtype_wd_q  <= '0;
            vl_wd_q     <= '0;
            vstart_wd_q <= '0;
            vxrm_wd_q   <= '0;
            vxsat_wd_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            vtype_req_q <= vtype_req_d;
            rs1_x0_q    <= rs1_x0_d;
            rd_x0_q     <= rd_x0_d;
            rdata_q     <= rdata_d;
            illegal_q   <= illegal_d;
            we_q        <= we_d;
            vtype_wd_q  <= vtype_wd_d;
            vl_wd_q     <= vl_wd_d;
            vstart_wd_q <= vstart_wd_d;
            vxrm_wd_q   <= vxrm_wd_d;
            vxsat_wd_q  <= vxsat_wd_d;
        end
    end

    assign req_ready        = rst_n && (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign resp_rdata       = rdata_q;
    assign resp_illegal     = illegal_q;
    assign csr_vtype_wr_en  = (state_q == S_WRITE) && we_q[4];
    assign csr_vl_wr_en     = (state_q == S_WRITE) && we_q[3];
    assign csr_vstart_wr_en = (state_q == S_WRITE) && we_q[2];
    assign csr_vxrm_wr_en   = (state_q == S_WRITE) && we_q[1];
    assign csr_vxsat_wr_en  = (state_q == S_WRITE) && we_q[0];
    assign csr_vtype_wdata  = vtype_wd_q;
    assign csr_vl_wdata     = vl_wd_q;
    assign csr_vstart_wdata = vstart_wd_q;
    assign csr_vxrm_wdata   = vxrm_wd_q;
    assign csr_vxsat_wdata  = vxsat_wd_q;

endmodule

// File: doc/riscv_v_csr_ctrl.md
Name: riscv_v_csr_ctrl

Overview:
- Write-side controller for the vector CSR file. It accepts Zicsr operations (CSRRW/CSRRS/CSRRC) and vsetvl/vsetvli operations from the scalar pipeline over a valid/ready request channel.
- It performs read-modify-write on the vector CSRs through the CSR file's data_in/wr_en/data_out ports.
- It returns the rd value over a valid/ready response channel. It sits between the decode/execute stage and the CSR file.

Parameters:
- XLEN, 32, scalar register width.
- VLEN, 128, vector register bits (ELEN=VLEN).
- MAX_LMUL, 8, largest LMUL.
- VL_W, $clog2(VLEN/8*MAX_LMUL) = 7, width of the vl/vstart fields; must match the CSR file.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_op  in  3  000 CSRRW, 001 CSRRS, 010 CSRRC, 011 VSETVLI, 100 VSETVL; others illegal
- req_csr_addr  in  12  CSR address (ignored for vset*)
- req_wdata  in  XLEN  rs1 value / uimm for CSR ops; AVL for vset*
- req_vtype  in  XLEN  requested vtype (zimm or rs2)
- req_rs1_x0  in  1  source is x0 / uimm==0
- req_rd_x0  in  1  destination is x0
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed
- resp_rdata  out  XLEN  value for rd
- resp_illegal  out  1  illegal-instruction flag, valid with resp_valid
- csr_vtype_rdata  in  9  CSR file vtype read (packed {vill,vma,vta,vsew[2:0],vlmul[2:0]})
- csr_vtype_wdata / csr_vtype_wr_en  out  9 / 1  vtype write
- csr_vl_rdata  in  VL_W  vl read
- csr_vl_wdata / csr_vl_wr_en  out  VL_W / 1  vl write
- csr_vstart_rdata  in  VL_W  vstart read
- csr_vstart_wdata / csr_vstart_wr_en  out  VL_W / 1  vstart write
- csr_vxrm_rdata  in  2  vxrm read
- csr_vxrm_wdata / csr_vxrm_wr_en  out  2 / 1  vxrm write
- csr_vxsat_rdata  in  1  vxsat read
- csr_vxsat_wdata / csr_vxsat_wr_en  out  1 / 1  vxsat write

Behaviour:

Reset (rst_n low, async):
- FSM to IDLE.
- req_ready=0 while reset is asserted, 1 in IDLE.
- resp_valid=0, resp_rdata=0, resp_illegal=0, all wr_en=0, all wdata=0.
- Reset mid-operation aborts it; no write pulse is issued afterwards.

FSM states IDLE -> READ -> WRITE -> RESP -> IDLE:
- IDLE: req_ready=1. On req_valid, latch all req_* fields and go to READ.
- READ: sample csr_*_rdata and compute old value, new values, write mask and illegal flag into registers. No wr_en is asserted. The CSR file's data_out bypasses data_in on wr_en, so reading and writing in the same cycle would form a combinational loop; the split is mandatory.
- WRITE: assert the masked wr_en signals for exactly one cycle with registered wdata.
- RESP: resp_valid=1. Hold resp_rdata/resp_illegal stable until resp_ready, then go to IDLE.
- Fixed latency: accept at cycle 0, write pulse at cycle 2, resp_valid from cycle 3.
- req_ready=0 outside IDLE. A new request can be accepted in the cycle after the handshake.

CSR address map, read value zero-extended to XLEN:
- 0x008 vstart (RW)
- 0x009 vxsat (RW)
- 0x00A vxrm (RW)
- 0x00F vcsr = {vxrm,vxsat} (RW; a write updates both)
- 0xC20 vl (RO)
- 0xC21 vtype (RO; reads as {vill at bit XLEN-1, bits[7:0]})
- 0xC22 vlenb (RO; constant VLEN/8 = 16)

CSR operation rules:
- New value: CSRRW = wdata; CSRRS = old|wdata; CSRRC = old&~wdata. Truncate to the field width.
- CSRRS/CSRRC with req_rs1_x0=1 perform no write and are legal on RO CSRs.
- CSRRW to an RO CSR, or CSRRS/CSRRC with rs1!=x0 to an RO CSR, is illegal.
- An unmapped address or reserved op is illegal.
- Illegal: resp_illegal=1, resp_rdata=0, no wr_en.
- Legal: resp_rdata = old value.

vset* rules:
- Decode req_vtype. vill=1 if any of the following holds:
  - bits[XLEN-1:8] are nonzero
  - vlmul==100
  - vsew>100
  - SEW > ELEN*LMUL
  - VLMAX == 0
- SEW = 8<<vsew. LMUL codes: 000..011 = 1/2/4/8; 101/110/111 = 1/8, 1/4, 1/2.
- VLMAX = VLEN*LMUL/SEW, saturated to 2**VL_W-1 = 127 (field-width limit).
- vl selection:
  - rs1!=x0: vl = min(AVL, VLMAX)
  - rs1==x0, rd!=x0: vl = VLMAX
  - rs1==x0, rd==x0: vl = min(csr_vl_rdata, VLMAX)
- Writes vtype = {0, vtype[7:0]}, vl, and vstart=0. resp_rdata = new vl.
- vill case: vtype=9'h100, vl=0, vstart=0, resp_rdata=0, resp_illegal=0.

Test Plan:
- Reset, then CSRRW 0x00A wdata=2 -> csr_vxrm_wr_en pulses at cycle 2 with wdata=2; resp_rdata=0 (old value); resp_illegal=0.
- VSETVLI vtype=0x0D0 (e32, m1, ta, ma), AVL=10 -> vtype wdata=0x0D0, vl wdata=4, vstart wdata=0; resp_rdata=4. Repeat with AVL=2 -> vl=2.
- VSETVLI vsew=000, vlmul=011 (e8 m8), rs1_x0=1, rd_x0=0 -> vl=127 (saturated); vsew=101 -> vtype=0x100, vl=0.
- CSRRW 0xC20, and CSRRW to 0x123 -> resp_illegal=1, resp_rdata=0, no wr_en; CSRRS 0xC22 with rs1_x0=1 -> resp_rdata=16.
- CSRRW 0x00F wdata=7 with vxrm=0, vxsat=0 -> vxrm wdata=3, vxsat wdata=1 in the same cycle; resp_rdata=0. CSRRC 0x00F wdata=1 -> vxsat=0, vxrm unchanged.
- resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready=0; assert rst_n=0 during WRITE -> all wr_en deassert immediately, FSM returns to IDLE.
